// File: rtl/branch_resolve_queue_pkg.sv
// Shared constants for the branch resolve queue and its users.
// Holds bus width, queue geometry and the branch opcode encodings.
package branch_resolve_queue_pkg;

  localparam int unsigned DATA_BUS  = 32;
  localparam int unsigned BRQ_DEPTH = 8;
  localparam int unsigned BRQ_TAG_W = $clog2(BRQ_DEPTH);

  localparam logic [6:0] SB_ALL = 7'b1100011;
  localparam logic [6:0] UJ_JAL = 7'b1101111;

endpackage

// File: rtl/branch_resolve_queue_array.sv
// Entry storage for the branch resolve queue: alloc and resolve write ports,
// a retire invalidate, a global clear, and one read port for the head entry.
module brq_entry_array
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned TAG_W = BRQ_TAG_W,
  parameter int unsigned XLEN  = DATA_BUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_idx,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             alloc_pred_taken,
  input  logic [XLEN-1:0]  alloc_pred_target,
  input  logic             res_en,
  input  logic [TAG_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  input  logic             retire_en,
  input  logic [TAG_W-1:0] rd_idx,
  output logic [DEPTH-1:0] valid,
  output logic [DEPTH-1:0] done,
  output logic [XLEN-1:0]  rd_pc,
  output logic             rd_pred_taken,
  output logic [XLEN-1:0]  rd_pred_target,
  output logic             rd_taken,
  output logic [XLEN-1:0]  rd_target
);

  logic [XLEN-1:0] pc_q          [DEPTH];
  logic            pred_taken_q  [DEPTH];
  logic [XLEN-1:0] pred_target_q [DEPTH];
  logic            taken_q       [DEPTH];
  logic [XLEN-1:0] target_q      [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
      done  <= '0;
    end else begin
      if (alloc_en) begin
        valid[alloc_idx] <= 1'b1;
        done[alloc_idx]  <= 1'b0;
      end
      if (res_en) done[res_idx] <= 1'b1;
      // Retire last: a same-edge resolve of the retiring entry must not revive it.
      if (retire_en) begin
        valid[rd_idx] <= 1'b0;
        done[rd_idx]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) begin
      pc_q[alloc_idx]          <= alloc_pc;
      pred_taken_q[alloc_idx]  <= alloc_pred_taken;
      pred_target_q[alloc_idx] <= alloc_pred_target;
    end
    if (res_en) begin
      taken_q[res_idx]  <= res_taken;
      target_q[res_idx] <= res_target;
    end
  end

  assign rd_pc          = pc_q[rd_idx];
  assign rd_pred_taken  = pred_taken_q[rd_idx];
  assign rd_pred_target = pred_target_q[rd_idx];
  assign rd_taken       = taken_q[rd_idx];
  assign rd_target      = target_q[rd_idx];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction tracker: allocates per predicted branch, resolves
// out of order by tag, retires in order with a training pulse and flush on mispredict.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned TAG_W = BRQ_TAG_W,
  parameter int unsigned XLEN  = DATA_BUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             alloc_pred_taken,
  input  logic [XLEN-1:0]  alloc_pred_target,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             train_valid,
  output logic             train_taken,
  output logic [XLEN-1:0]  train_pc,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [TAG_W:0]   count
);

  logic [TAG_W:0]   head, tail;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             full;
  logic [DEPTH-1:0] valid, done;
  logic [XLEN-1:0]  h_pc, h_pred_target, h_target;
  logic             h_pred_taken, h_taken;
  logic             retire, mispredict, flush_now, alloc_en, res_en;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign count       = tail - head;

  assign retire     = rdy && valid[head_idx] && done[head_idx];
  assign mispredict = (h_taken != h_pred_taken) || (h_taken && (h_target != h_pred_target));
  assign flush_now  = retire && mispredict;
  // Work arriving on the edge of a flush belongs to the wrong path.
  assign alloc_en   = alloc_valid && !full && rdy && !flush_now;
  assign res_en     = res_valid && rdy && valid[res_tag] && !flush_now;

  brq_entry_array #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W),
    .XLEN (XLEN)
  ) u_array (
    .clk              (clk),
    .rst              (rst),
    .clear            (flush_now),
    .alloc_en         (alloc_en),
    .alloc_idx        (tail_idx),
    .alloc_pc         (alloc_pc),
    .alloc_pred_taken (alloc_pred_taken),
    .alloc_pred_target(alloc_pred_target),
    .res_en           (res_en),
    .res_idx          (res_tag),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .retire_en        (retire),
    .rd_idx           (head_idx),
    .valid            (valid),
    .done             (done),
    .rd_pc            (h_pc),
    .rd_pred_taken    (h_pred_taken),
    .rd_pred_target   (h_pred_target),
    .rd_taken         (h_taken),
    .rd_target        (h_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      train_valid <= 1'b0;
      train_taken <= 1'b0;
      train_pc    <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      train_valid <= 1'b0;
      flush       <= 1'b0;
      if (retire) begin
        train_valid <= 1'b1;
        train_taken <= h_taken;
        train_pc    <= h_pc;
        if (mispredict) begin
          flush       <= 1'b1;
          redirect_pc <= h_taken ? h_target : h_pc + XLEN'(4);
          head        <= '0;
          tail        <= '0;
        end else begin
          head <= head + 1'b1;
        end
      end
      if (alloc_en) tail <= tail + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios then random
// traffic, compared against a program-order queue model of the tracker.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst, rdy;
  logic             alloc_valid, alloc_pred_taken, alloc_ready;
  logic [XLEN-1:0]  alloc_pc, alloc_pred_target;
  logic [TAG_W-1:0] alloc_tag, res_tag;
  logic             res_valid, res_taken;
  logic [XLEN-1:0]  res_target;
  logic             train_valid, train_taken, flush;
  logic [XLEN-1:0]  train_pc, redirect_pc;
  logic [TAG_W:0]   count;

  branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
    .alloc_pred_target(alloc_pred_target), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .train_valid(train_valid), .train_taken(train_taken), .train_pc(train_pc),
    .flush(flush), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            pt;
    logic [XLEN-1:0] ptgt;
    logic            done;
    logic            tk;
    logic [XLEN-1:0] tgt;
  } ent_t;

  ent_t q[$];            // in-flight branches, oldest first
  int   head_tag;
  logic exp_tv, exp_tt, exp_fl;
  logic [XLEN-1:0] exp_tpc, exp_rpc;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check pre-edge combinational outputs, advance the model, check after edge.
  task automatic step();
    ent_t e, t;
    bit   do_ret, flushing;
    int   n;
    if (!rst) begin
      check("alloc_ready", alloc_ready, (q.size() < DEPTH));
      check("alloc_tag", alloc_tag, (head_tag + q.size()) % DEPTH);
      check("count", count, q.size());
    end
    if (rst) begin
      q.delete(); head_tag = 0;
      exp_tv = 0; exp_tt = 0; exp_tpc = '0; exp_fl = 0; exp_rpc = '0;
    end else begin
      exp_tv = 0; exp_fl = 0;
      if (rdy) begin
        do_ret = (q.size() > 0) && q[0].done;
        flushing = 0;
        if (do_ret) begin
          e = q[0];
          exp_tv = 1; exp_tt = e.tk; exp_tpc = e.pc;
          if ((e.tk != e.pt) || (e.tk && e.tgt != e.ptgt)) begin
            flushing = 1; exp_fl = 1;
            exp_rpc = e.tk ? e.tgt : e.pc + 32'd4;
          end
        end
        if (flushing) begin
          q.delete(); head_tag = 0;
        end else begin
          n = q.size();
          if (res_valid)
            for (int i = 0; i < n; i++)
              if ((head_tag + i) % DEPTH == int'(res_tag)) begin
                t = q[i]; t.done = 1; t.tk = res_taken; t.tgt = res_target; q[i] = t;
              end
          if (alloc_valid && n < DEPTH) begin
            t.pc = alloc_pc; t.pt = alloc_pred_taken; t.ptgt = alloc_pred_target;
            t.done = 0; t.tk = 0; t.tgt = '0;
            q.push_back(t);
          end
          if (do_ret) begin
            void'(q.pop_front());
            head_tag = (head_tag + 1) % DEPTH;
          end
        end
      end
    end
    @(posedge clk); #1;
    check("train_valid", train_valid, exp_tv);
    check("flush", flush, exp_fl);
    if (exp_tv) begin
      check("train_taken", train_taken, exp_tt);
      check("train_pc", train_pc, exp_tpc);
    end
    if (exp_fl) check("redirect_pc", redirect_pc, exp_rpc);
  endtask

  task automatic idle_inputs();
    rst = 0; rdy = 1; alloc_valid = 0; res_valid = 0;
    alloc_pc = '0; alloc_pred_taken = 0; alloc_pred_target = '0;
    res_tag = '0; res_taken = 0; res_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; step(); rst = 0;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    alloc_valid = 1; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_target = ptgt;
  endtask

  task automatic set_res(input int tag, input logic tk, input logic [31:0] tgt);
    res_valid = 1; res_tag = TAG_W'(tag); res_taken = tk; res_target = tgt;
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    idle_inputs(); set_alloc(pc, pt, ptgt); step(); idle_inputs();
  endtask

  task automatic res1(input int tag, input logic tk, input logic [31:0] tgt);
    idle_inputs(); set_res(tag, tk, tgt); step(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    // Reset state
    do_reset();
    check("rst_train_pc", train_pc, 0);
    check("rst_train_taken", train_taken, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_count", count, 0);

    // Single correctly predicted branch
    alloc1(32'h100, 1, 32'h120);
    res1(0, 1, 32'h120);
    step(); step();
    check("t1_count", count, 0);

    // Out-of-order resolve, in-order retire
    do_reset();
    alloc1(32'h10, 0, 32'h14);
    alloc1(32'h20, 0, 32'h24);
    alloc1(32'h30, 0, 32'h34);
    res1(2, 0, 32'h0);
    res1(1, 0, 32'h0);
    check("t2_no_early_retire", count, 3);
    res1(0, 0, 32'h0);
    repeat (4) step();

    // Predicted taken, actually not taken; alloc on the flush edge is dropped
    do_reset();
    alloc1(32'h200, 1, 32'h240);
    res1(0, 0, 32'h0);
    set_alloc(32'h500, 0, 32'h504); step(); idle_inputs();
    check("t3_flush", flush, 1);
    check("t3_redirect", redirect_pc, 32'h204);
    check("t3_count", count, 0);

    // Fill, full boundary, wrap-around tag
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc1(32'h1000 + 32'(i) * 4, 0, 32'h0);
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_count", count, 8);
    res1(0, 0, 32'h0);
    set_alloc(32'h2000, 0, 32'h0); step(); idle_inputs();   // retire edge, still full
    check("t4_ready_after", alloc_ready, 1);
    check("t4_wrap_tag", alloc_tag, 0);
    alloc1(32'h2004, 0, 32'h0);
    check("t4_count_after", count, 8);

    // Wrong taken target, retire held off by rdy=0
    do_reset();
    alloc1(32'h400, 1, 32'h2F0);
    res1(0, 1, 32'h300);
    rdy = 0; repeat (3) step();
    rdy = 1; step();
    check("t5_redirect", redirect_pc, 32'h300);

    // Reset with entries in flight and a pending resolve
    do_reset();
    for (int i = 0; i < 5; i++) alloc1(32'h600 + 32'(i) * 4, 0, 32'h0);
    set_res(3, 1, 32'h999); rst = 1; step(); idle_inputs();
    check("t6_count", count, 0);
    check("t6_tv", train_valid, 0);
    res1(2, 0, 32'h0);
    step();
    check("t6_old_tag_ignored", count, 0);

    // Pc+4 wraps at the top of the address space
    alloc1(32'hFFFF_FFFC, 1, 32'h40);
    res1(0, 0, 32'h0);
    step();
    check("t7_wrap_redirect", redirect_pc, 32'h0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) rst = 1;
      if ($urandom_range(0, 2) != 0) begin
        logic [31:0] pc;
        logic pt;
        pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        pt = $urandom_range(0, 1);
        set_alloc(pc, pt, pt ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4);
      end
      if ($urandom_range(0, 1) != 0) begin
        int tag;
        logic tk;
        logic [31:0] tgt;
        if (q.size() > 0 && $urandom_range(0, 4) != 0) begin
          int k;
          k = $urandom_range(0, q.size() - 1);
          tag = (head_tag + k) % DEPTH;
          tk = ($urandom_range(0, 9) == 0) ? !q[k].pt : q[k].pt;
          tgt = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC) : q[k].ptgt;
        end else begin
          tag = $urandom_range(0, DEPTH - 1);
          tk = $urandom_range(0, 1);
          tgt = $urandom;
        end
        set_res(tag, tk, tgt);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
